prog_loader: RTL and testbench

- Writer side of the processor's program-memory fetch path: accepts the program as a stream of 4-bit nibbles and writes assembled 8-bit bytes into a writable program memory at sequential 12-bit addresses.
- Holds the processor disabled while loading.
- Releases it with a one-cycle restart pulse once loading ends.
- Sits between the board-level nibble source (pushbuttons/host) and the program memory write port plus the core's `ena` input.

---
 rtl/prog_loader_pkg.sv | 17 +
 rtl/prog_loader_if.sv | 30 +++
 rtl/prog_loader_nibble_packer.sv | 34 +++
 rtl/prog_loader.sv | 95 +++++++++
 tb/tb_prog_loader.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared constants and FSM encoding for the program loader
package prog_loader_pkg;

    localparam int NIB_W  = 4;
    localparam int BYTE_W = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HI_NIB = 3'd1;
    localparam logic [2:0] ST_LO_NIB = 3'd2;
    localparam logic [2:0] ST_WRITE  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    function automatic logic state_busy(input logic [2:0] st);
        return (st == ST_HI_NIB) || (st == ST_LO_NIB) || (st == ST_WRITE);
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - nibble source, program memory write port and core control bundle
interface prog_loader_if #(
    parameter int ADDR_W = 12
);
    import prog_loader_pkg::*;

    logic              start;
    logic [NIB_W-1:0]  nib_in;
    logic              nib_valid;
    logic              finish;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [BYTE_W-1:0] mem_data;
    logic              cpu_ena;
    logic              cpu_rst;
    logic              busy;
    logic [ADDR_W:0]   byte_count;
    logic              err_partial;

    modport master (
        output start, nib_in, nib_valid, finish,
        input  mem_we, mem_addr, mem_data, cpu_ena, cpu_rst, busy, byte_count, err_partial
    );

    modport slave (
        input  start, nib_in, nib_valid, finish,
        output mem_we, mem_addr, mem_data, cpu_ena, cpu_rst, busy, byte_count, err_partial
    );

endinterface

// File: rtl/prog_loader_nibble_packer.sv
// rtl/prog_loader_nibble_packer.sv - two nibble registers assembled into one program byte
module prog_loader_nibble_packer
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_hi,
    input  logic              load_lo,
    input  logic [NIB_W-1:0]  nib,
    output logic [BYTE_W-1:0] byte_q
);

    logic [NIB_W-1:0] hi_q;
    logic [NIB_W-1:0] lo_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
        end else if (load_hi) begin
            hi_q <= nib;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lo_q <= '0;
        end else if (load_lo) begin
            lo_q <= nib;
        end
    end

    assign byte_q = {hi_q, lo_q};

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - nibble-stream program loader driving program memory writes and core enable
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096
) (
    input  logic         clk,
    input  logic         reset,
    prog_loader_if.slave bus
);

    localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W+1)'(DEPTH - 1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   count;
    logic              err;
    logic              rst_pulse;
    logic              load_hi;
    logic              load_lo;

    // finish wins over a coincident nibble strobe, so the nibble is never latched
    assign load_hi = (state == ST_HI_NIB) && bus.nib_valid && !bus.finish;
    assign load_lo = (state == ST_LO_NIB) && bus.nib_valid && !bus.finish;

    prog_loader_nibble_packer u_packer (
        .clk     (clk),
        .reset   (reset),
        .load_hi (load_hi),
        .load_lo (load_lo),
        .nib     (bus.nib_in),
        .byte_q  (bus.mem_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            addr      <= '0;
            count     <= '0;
            err       <= 1'b0;
            rst_pulse <= 1'b0;
        end else begin
            rst_pulse <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state <= ST_HI_NIB;
                        addr  <= '0;
                        count <= '0;
                        err   <= 1'b0;
                    end
                end
                ST_HI_NIB: begin
                    if (bus.finish) begin
                        state     <= ST_DONE;
                        rst_pulse <= 1'b1;
                    end else if (bus.nib_valid) begin
                        state <= ST_LO_NIB;
                    end
                end
                ST_LO_NIB: begin
                    if (bus.finish) begin
                        state     <= ST_DONE;
                        err       <= 1'b1;
                        rst_pulse <= 1'b1;
                    end else if (bus.nib_valid) begin
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    addr  <= addr + 1'b1;
                    count <= count + 1'b1;
                    // the byte that fills the memory ends the load on its own
                    if (count == LAST_COUNT) begin
                        state     <= ST_DONE;
                        rst_pulse <= 1'b1;
                    end else begin
                        state <= ST_HI_NIB;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_we      = (state == ST_WRITE);
    assign bus.mem_addr    = addr;
    assign bus.busy        = state_busy(state);
    assign bus.cpu_rst     = rst_pulse;
    assign bus.cpu_ena     = !(state_busy(state) || rst_pulse);
    assign bus.byte_count  = count;
    assign bus.err_partial = err;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader at full and four-byte depth
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       finish;
    logic       nib_valid;
    logic [3:0] nib_in;

    always #5 clk = ~clk;

    prog_loader_if #(.ADDR_W(12)) if_a ();
    prog_loader_if #(.ADDR_W(12)) if_b ();

    assign if_a.start = start;  assign if_a.finish = finish;
    assign if_a.nib_valid = nib_valid;  assign if_a.nib_in = nib_in;
    assign if_b.start = start;  assign if_b.finish = finish;
    assign if_b.nib_valid = nib_valid;  assign if_b.nib_in = nib_in;

    prog_loader #(.ADDR_W(12), .DEPTH(4096)) dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
    prog_loader #(.ADDR_W(12), .DEPTH(4))    dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));

    int passed = 0;
    int total  = 0;
    logic [19:0] cap_a[$];
    logic [19:0] cap_b[$];
    int rst_a = 0;
    int rst_b = 0;

    always @(negedge clk) begin
        if (if_a.mem_we) cap_a.push_back({if_a.mem_addr, if_a.mem_data});
        if (if_b.mem_we) cap_b.push_back({if_b.mem_addr, if_b.mem_data});
        if (if_a.cpu_rst) rst_a++;
        if (if_b.cpu_rst) rst_b++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_scoreboard();
        cap_a.delete(); cap_b.delete(); rst_a = 0; rst_b = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(1); start = 1'b0;
    endtask

    task automatic pulse_finish();
        finish = 1'b1; tick(1); finish = 1'b0;
    endtask

    task automatic send_nib(input logic [3:0] n, input int gap);
        nib_valid = 1'b1; nib_in = n; tick(1); nib_valid = 1'b0; tick(gap);
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(2); reset = 1'b0; tick(1);
    endtask

    task automatic test_reset();
        reset = 1'b1; tick(2);
        total++; if (if_a.mem_we !== 1'b0) $display("FAIL reset_mem_we got %b want 0", if_a.mem_we); else passed++;
        total++; if (if_a.mem_addr !== 12'h000) $display("FAIL reset_mem_addr got %h want 000", if_a.mem_addr); else passed++;
        total++; if (if_a.mem_data !== 8'h00) $display("FAIL reset_mem_data got %h want 00", if_a.mem_data); else passed++;
        total++; if (if_a.cpu_ena !== 1'b1) $display("FAIL reset_cpu_ena got %b want 1", if_a.cpu_ena); else passed++;
        total++; if (if_a.cpu_rst !== 1'b0) $display("FAIL reset_cpu_rst got %b want 0", if_a.cpu_rst); else passed++;
        total++; if (if_a.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", if_a.busy); else passed++;
        total++; if (if_a.byte_count !== 13'd0) $display("FAIL reset_byte_count got %0d want 0", if_a.byte_count); else passed++;
        total++; if (if_a.err_partial !== 1'b0) $display("FAIL reset_err_partial got %b want 0", if_a.err_partial); else passed++;
        reset = 1'b0; tick(1);
    endtask

    task automatic test_basic_load();
        logic [19:0] exp[2];
        exp[0] = {12'h000, 8'hA3};
        exp[1] = {12'h001, 8'h0F};
        clear_scoreboard();
        pulse_start();
        total++; if (if_a.busy !== 1'b1) $display("FAIL basic_busy got %b want 1", if_a.busy); else passed++;
        total++; if (if_a.cpu_ena !== 1'b0) $display("FAIL basic_ena_loading got %b want 0", if_a.cpu_ena); else passed++;
        send_nib(4'hA, 1);
        nib_valid = 1'b1; nib_in = 4'h3; tick(1); nib_valid = 1'b0;
        total++; if (if_a.mem_we !== 1'b1) $display("FAIL basic_latency_we got %b want 1", if_a.mem_we); else passed++;
        total++; if ({if_a.mem_addr, if_a.mem_data} !== exp[0]) $display("FAIL basic_first_write got %h want %h", {if_a.mem_addr, if_a.mem_data}, exp[0]); else passed++;
        tick(1);
        total++; if (if_a.mem_we !== 1'b0) $display("FAIL basic_we_single got %b want 0", if_a.mem_we); else passed++;
        send_nib(4'h0, 1);
        send_nib(4'hF, 1);
        pulse_finish();
        total++; if (if_a.cpu_rst !== 1'b1) $display("FAIL basic_cpu_rst_pulse got %b want 1", if_a.cpu_rst); else passed++;
        total++; if (if_a.cpu_ena !== 1'b0) $display("FAIL basic_ena_in_pulse got %b want 0", if_a.cpu_ena); else passed++;
        tick(1);
        total++; if (if_a.cpu_rst !== 1'b0) $display("FAIL basic_cpu_rst_end got %b want 0", if_a.cpu_rst); else passed++;
        total++; if (if_a.cpu_ena !== 1'b1) $display("FAIL basic_ena_after got %b want 1", if_a.cpu_ena); else passed++;
        total++; if (cap_a.size() !== 2) $display("FAIL basic_write_count got %0d want 2", cap_a.size()); else passed++;
        for (int i = 0; i < 2 && i < cap_a.size(); i++) begin
            total++; if (cap_a[i] !== exp[i]) $display("FAIL basic_write%0d got %h want %h", i, cap_a[i], exp[i]); else passed++;
        end
        total++; if (if_a.byte_count !== 13'd2) $display("FAIL basic_byte_count got %0d want 2", if_a.byte_count); else passed++;
        total++; if (if_a.err_partial !== 1'b0) $display("FAIL basic_err got %b want 0", if_a.err_partial); else passed++;
        total++; if (rst_a !== 1) $display("FAIL basic_rst_cycles got %0d want 1", rst_a); else passed++;
    endtask

    task automatic test_partial();
        clear_scoreboard();
        pulse_start();
        send_nib(4'h5, 1);
        pulse_finish();
        tick(2);
        total++; if (cap_a.size() !== 0) $display("FAIL partial_writes got %0d want 0", cap_a.size()); else passed++;
        total++; if (if_a.err_partial !== 1'b1) $display("FAIL partial_err got %b want 1", if_a.err_partial); else passed++;
        total++; if (if_a.byte_count !== 13'd0) $display("FAIL partial_byte_count got %0d want 0", if_a.byte_count); else passed++;
        total++; if (rst_a !== 1) $display("FAIL partial_rst_cycles got %0d want 1", rst_a); else passed++;
        total++; if (if_a.busy !== 1'b0) $display("FAIL partial_busy got %b want 0", if_a.busy); else passed++;
    endtask

    task automatic test_finish_priority();
        clear_scoreboard();
        pulse_start();
        send_nib(4'h9, 1);
        nib_valid = 1'b1; nib_in = 4'h6; finish = 1'b1; tick(1);
        nib_valid = 1'b0; finish = 1'b0; tick(3);
        total++; if (cap_a.size() !== 0) $display("FAIL prio_writes got %0d want 0", cap_a.size()); else passed++;
        total++; if (if_a.err_partial !== 1'b1) $display("FAIL prio_err got %b want 1", if_a.err_partial); else passed++;
        total++; if (rst_a !== 1) $display("FAIL prio_rst_cycles got %0d want 1", rst_a); else passed++;
    endtask

    task automatic test_start_ignored();
        clear_scoreboard();
        pulse_start();
        send_nib(4'h1, 1); send_nib(4'h2, 1);
        pulse_start();
        send_nib(4'h3, 1); send_nib(4'h4, 1);
        total++; if (if_a.mem_addr !== 12'h002) $display("FAIL midstart_addr got %h want 002", if_a.mem_addr); else passed++;
        pulse_finish(); tick(2);
        total++; if (cap_a.size() !== 2) $display("FAIL midstart_writes got %0d want 2", cap_a.size()); else passed++;
        if (cap_a.size() == 2) begin
            total++; if (cap_a[1] !== {12'h001, 8'h34}) $display("FAIL midstart_second got %h want 00134", cap_a[1]); else passed++;
        end
        total++; if (if_a.byte_count !== 13'd2) $display("FAIL midstart_byte_count got %0d want 2", if_a.byte_count); else passed++;
    endtask

    task automatic test_reset_midload();
        clear_scoreboard();
        pulse_start();
        send_nib(4'h7, 1);
        reset = 1'b1; tick(1);
        total++; if (if_a.busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", if_a.busy); else passed++;
        total++; if (if_a.cpu_ena !== 1'b1) $display("FAIL rstmid_ena got %b want 1", if_a.cpu_ena); else passed++;
        total++; if (if_a.mem_data !== 8'h00) $display("FAIL rstmid_data got %h want 00", if_a.mem_data); else passed++;
        total++; if (if_a.byte_count !== 13'd0) $display("FAIL rstmid_count got %0d want 0", if_a.byte_count); else passed++;
        reset = 1'b0; tick(1);
        total++; if (rst_a !== 0) $display("FAIL rstmid_no_pulse got %0d want 0", rst_a); else passed++;
        pulse_start();
        send_nib(4'hC, 1); send_nib(4'hD, 1);
        pulse_finish(); tick(2);
        total++; if (cap_a.size() !== 1) $display("FAIL rstmid_writes got %0d want 1", cap_a.size()); else passed++;
        if (cap_a.size() == 1) begin
            total++; if (cap_a[0] !== {12'h000, 8'hCD}) $display("FAIL rstmid_reload got %h want 000cd", cap_a[0]); else passed++;
        end
    endtask

    task automatic test_depth_limit();
        logic [3:0] nibs[10];
        do_reset();
        clear_scoreboard();
        for (int i = 0; i < 10; i++) nibs[i] = 4'($urandom_range(0, 15));
        pulse_start();
        for (int i = 0; i < 10; i++) send_nib(nibs[i], 1);
        pulse_finish(); tick(2);
        total++; if (cap_b.size() !== 4) $display("FAIL depth_writes got %0d want 4", cap_b.size()); else passed++;
        for (int i = 0; i < 4 && i < cap_b.size(); i++) begin
            total++;
            if (cap_b[i] !== {12'(i), nibs[2*i], nibs[2*i+1]})
                $display("FAIL depth_write%0d got %h want %h", i, cap_b[i], {12'(i), nibs[2*i], nibs[2*i+1]});
            else passed++;
        end
        total++; if (if_b.byte_count !== 13'd4) $display("FAIL depth_byte_count got %0d want 4", if_b.byte_count); else passed++;
        total++; if (if_b.err_partial !== 1'b0) $display("FAIL depth_err got %b want 0", if_b.err_partial); else passed++;
        total++; if (if_b.cpu_ena !== 1'b1) $display("FAIL depth_ena got %b want 1", if_b.cpu_ena); else passed++;
        total++; if (rst_b !== 1) $display("FAIL depth_rst_cycles got %0d want 1", rst_b); else passed++;
        total++; if (if_a.byte_count !== 13'd5) $display("FAIL depth_full_count got %0d want 5", if_a.byte_count); else passed++;
    endtask

    task automatic test_random();
        logic [3:0] nibs[12];
        int n, nb_a, nb_b;
        logic err_a, err_b;
        for (int it = 0; it < 10; it++) begin
            clear_scoreboard();
            n = $urandom_range(0, 11);
            for (int i = 0; i < n; i++) nibs[i] = 4'($urandom_range(0, 15));
            nb_a  = n / 2;
            nb_b  = (nb_a < 4) ? nb_a : 4;
            err_a = (n % 2) == 1;
            err_b = (nb_a < 4) && ((n % 2) == 1);
            pulse_start();
            for (int i = 0; i < n; i++) send_nib(nibs[i], $urandom_range(1, 3));
            pulse_finish(); tick(2);
            total++; if (cap_a.size() !== nb_a) $display("FAIL rand%0d_writes_a got %0d want %0d", it, cap_a.size(), nb_a); else passed++;
            total++; if (cap_b.size() !== nb_b) $display("FAIL rand%0d_writes_b got %0d want %0d", it, cap_b.size(), nb_b); else passed++;
            for (int i = 0; i < nb_a && i < cap_a.size(); i++) begin
                total++;
                if (cap_a[i] !== {12'(i), nibs[2*i], nibs[2*i+1]})
                    $display("FAIL rand%0d_byte%0d got %h want %h", it, i, cap_a[i], {12'(i), nibs[2*i], nibs[2*i+1]});
                else passed++;
            end
            total++; if (if_a.byte_count !== 13'(nb_a)) $display("FAIL rand%0d_count_a got %0d want %0d", it, if_a.byte_count, nb_a); else passed++;
            total++; if (if_b.byte_count !== 13'(nb_b)) $display("FAIL rand%0d_count_b got %0d want %0d", it, if_b.byte_count, nb_b); else passed++;
            total++; if (if_a.err_partial !== err_a) $display("FAIL rand%0d_err_a got %b want %b", it, if_a.err_partial, err_a); else passed++;
            total++; if (if_b.err_partial !== err_b) $display("FAIL rand%0d_err_b got %b want %b", it, if_b.err_partial, err_b); else passed++;
            total++; if (rst_a !== 1 || rst_b !== 1) $display("FAIL rand%0d_rst_cycles got %0d/%0d want 1/1", it, rst_a, rst_b); else passed++;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; finish = 1'b0; nib_valid = 1'b0; nib_in = 4'h0;
        tick(1);
        test_reset();
        test_basic_load();
        test_partial();
        test_finish_priority();
        test_start_ignored();
        test_reset_midload();
        test_depth_limit();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
